// File: rtl/mopshub_elink_pkg.sv
// Shared e-link definitions: frame delimiters, CRC polynomial, receive FSM states, frame geometry.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mopshub_elink_pkg;

    localparam logic [7:0] DEF_SOP_BYTE = 8'h3C;
    localparam logic [7:0] DEF_EOP_BYTE = 8'hDC;
    localparam logic [7:0] DEF_CRC_POLY = 8'h07;
    localparam int         DEF_CNT_W    = 16;

    localparam int FRAME_PAYLOAD_BYTES = 10;
    localparam int UPLINK_W            = 76;

    typedef enum logic [1:0] {HUNT, PAYLOAD, CRC, EOP} elink_rx_state_t;

endpackage

// File: rtl/elink_uplink_deserializer_if.sv
// Host-side bundle of the uplink receiver: held word with valid/ack, event pulses and counters.
// Latency: n/a (wiring only).
// Backpressure: data_ack_i frees the single holding slot; there is no other stall path.
interface elink_uplink_deserializer_if
    import mopshub_elink_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic [UPLINK_W-1:0] data_rec_o;
    logic                data_valid_o;
    logic                data_ack_i;
    logic                irq_elink_rec;
    logic                crc_err_o;
    logic                frame_err_o;
    logic                overflow_o;
    logic [CNT_W-1:0]    good_cnt_o;
    logic [CNT_W-1:0]    err_cnt_o;

    modport master (
        output data_rec_o, data_valid_o, irq_elink_rec, crc_err_o,
               frame_err_o, overflow_o, good_cnt_o, err_cnt_o,
        input  data_ack_i
    );

    modport slave (
        input  data_rec_o, data_valid_o, irq_elink_rec, crc_err_o,
               frame_err_o, overflow_o, good_cnt_o, err_cnt_o,
        output data_ack_i
    );
endinterface

// File: rtl/elink_uplink_deserializer_crc8.sv
// Byte-wide next-state function of the MSB-first CRC-8 (no reflection), shared by rx and tx.
// Latency: combinational.
// Backpressure: none.
module elink_crc8 #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);
    // Eight serial shift steps unrolled, most significant data bit first
    always_comb begin
        logic [7:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ byte_in[i]) begin
                c = {c[6:0], 1'b0} ^ POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end
endmodule

// File: rtl/elink_uplink_deserializer.sv
// Uplink e-link receiver: SOP hunt, 76-bit word reassembly, CRC-8 and EOP check, 1-entry hold register.
// Latency: data_valid_o rises 52 clk after the first SOP dibit (the edge after the last EOP dibit).
// Backpressure: none toward the link; a good frame finishing while the hold register is full is dropped (overflow_o).
module elink_uplink_deserializer
    import mopshub_elink_pkg::*;
#(
    parameter logic [7:0] SOP_BYTE = DEF_SOP_BYTE,
    parameter logic [7:0] EOP_BYTE = DEF_EOP_BYTE,
    parameter logic [7:0] CRC_POLY = DEF_CRC_POLY,
    parameter int         CNT_W    = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  rx_elink2bit,
    elink_uplink_deserializer_if.master up
);
    localparam logic [3:0] LAST_BYTE = 4'(FRAME_PAYLOAD_BYTES - 1);

    elink_rx_state_t     state, state_nxt;
    logic [7:0]          win;
    logic [1:0]          dibit_cnt;
    logic [3:0]          byte_cnt;
    logic [7:0]          crc, crc_nxt;
    logic [UPLINK_W-1:0] stage, data_rec;
    logic                data_valid, irq, crc_err, frame_err, overflow;
    logic [CNT_W-1:0]    good_cnt, err_cnt;

    // Decision strobes; all act on the registered window, so a byte is judged one edge after it completes
    logic byte_rdy, sop_hit;
    logic lock, pay_byte, crc_bad, eop_bad, eop_good, load, ovf_drop;

    assign byte_rdy = (dibit_cnt == 2'd3);
    assign sop_hit  = (win == SOP_BYTE);

    elink_crc8 #(.POLY(CRC_POLY)) u_crc (
        .crc_in  (crc),
        .byte_in (win),
        .crc_out (crc_nxt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_nxt;
    end

    // FSM next-state: SOP bytes inside a frame are data, no resync until the frame ends or drops
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (sop_hit) state_nxt = PAYLOAD;
            PAYLOAD: if (byte_rdy && byte_cnt == LAST_BYTE) state_nxt = CRC;
            CRC:     if (byte_rdy) state_nxt = (win == crc) ? EOP : HUNT;
            EOP:     if (byte_rdy) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    // FSM outputs: per-byte actions and the end-of-frame verdict
    always_comb begin
        lock     = (state == HUNT) && sop_hit;
        pay_byte = (state == PAYLOAD) && byte_rdy;
        crc_bad  = (state == CRC) && byte_rdy && (win != crc);
        eop_bad  = (state == EOP) && byte_rdy && (win != EOP_BYTE);
        eop_good = (state == EOP) && byte_rdy && (win == EOP_BYTE);
        // A same-cycle ack frees the slot, so the new word loads instead of overflowing
        load     = eop_good && (!data_valid || up.data_ack_i);
        ovf_drop = eop_good && data_valid && !up.data_ack_i;
    end

    // Shift window, byte phase, CRC accumulator and staging register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win       <= '0;
            dibit_cnt <= '0;
            byte_cnt  <= '0;
            crc       <= '0;
            stage     <= '0;
        end else begin
            win       <= {win[5:0], rx_elink2bit};
            dibit_cnt <= lock ? 2'd0 : dibit_cnt + 2'd1;
            if (lock) begin
                byte_cnt <= '0;
                crc      <= '0;
            end else if (pay_byte) begin
                byte_cnt <= byte_cnt + 4'd1;
                crc      <= crc_nxt;
                // The 4 padding bits of byte 0 fall off the top after all ten bytes
                stage    <= {stage[UPLINK_W-9:0], win};
            end
        end
    end

    // Holding register, event pulses and saturating counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_rec   <= '0;
            data_valid <= 1'b0;
            irq        <= 1'b0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            good_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            if (load) begin
                data_rec   <= stage;
                data_valid <= 1'b1;
            end else if (up.data_ack_i && data_valid) begin
                data_valid <= 1'b0;
            end
            irq       <= load;
            crc_err   <= crc_bad;
            frame_err <= eop_bad;
            overflow  <= ovf_drop;
            if (load && good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
            if ((crc_bad || eop_bad || ovf_drop) && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign up.data_rec_o    = data_rec;
    assign up.data_valid_o  = data_valid;
    assign up.irq_elink_rec = irq;
    assign up.crc_err_o     = crc_err;
    assign up.frame_err_o   = frame_err;
    assign up.overflow_o    = overflow;
    assign up.good_cnt_o    = good_cnt;
    assign up.err_cnt_o     = err_cnt;

endmodule

// File: tb/tb_elink_uplink_deserializer.sv
// Scoreboard bench for the uplink e-link receiver: frames built from SOP/payload/CRC/EOP bytes.
// Expected events are queued when a frame starts and popped by a monitor on every DUT pulse.
// Holding-register occupancy, acks and counters are tracked by a small reference model.
module tb_elink_uplink_deserializer;
    import mopshub_elink_pkg::*;

    localparam int K_GOOD = 0;
    localparam int K_CRC  = 1;
    localparam int K_FRM  = 2;
    localparam int K_OVF  = 3;

    typedef struct {
        int          kind;
        logic [75:0] data;
        int          start;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] rx  = 2'b00;
    int         cyc = 0;

    int total = 0;
    int bad   = 0;

    exp_t        sb[$];
    bit          model_valid = 1'b0;
    logic [75:0] model_data  = '0;
    int          model_good  = 0;
    int          model_err   = 0;

    elink_uplink_deserializer_if #(.CNT_W(16)) up_if ();

    elink_uplink_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .rx_elink2bit (rx),
        .up           (up_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC as the remainder of msg*x^8 divided by x^8+poly (long division)
    function automatic logic [7:0] ref_crc(input logic [79:0] msg);
        logic [87:0] r;
        r = {msg, 8'h00};
        for (int i = 87; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, DEF_CRC_POLY};
        end
        return r[7:0];
    endfunction

    // Monitor: every DUT pulse must match the oldest queued expectation
    int   mon_n;
    int   mon_k;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            mon_n = int'(up_if.irq_elink_rec) + int'(up_if.crc_err_o)
                  + int'(up_if.frame_err_o) + int'(up_if.overflow_o);
            if (mon_n > 1) begin
                check("single_pulse", 80'(mon_n), 80'(1));
            end else if (mon_n == 1) begin
                mon_k = up_if.irq_elink_rec ? K_GOOD : up_if.crc_err_o ? K_CRC :
                        up_if.frame_err_o ? K_FRM : K_OVF;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: kind %0d seen with nothing expected", mon_k);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_kind", 80'(mon_k), 80'(mon_e.kind));
                    check("event_latency", 80'(cyc - mon_e.start), 80'(mon_e.lat));
                    if (mon_e.kind == K_GOOD || mon_e.kind == K_OVF) begin
                        check("held_data", {4'h0, up_if.data_rec_o}, {4'h0, mon_e.data});
                        check("held_valid", 80'(up_if.data_valid_o), 80'(1));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 2'b00;
        end
    endtask

    // One idle dibit first so a previous frame's verdict never coincides with this ack
    task automatic do_ack();
        @(negedge clk);
        rx = 2'b00;
        @(negedge clk);
        up_if.data_ack_i = 1'b1;
        @(negedge clk);
        up_if.data_ack_i = 1'b0;
        model_valid = 1'b0;
        check("ack_clears_valid", 80'(up_if.data_valid_o), 80'(0));
    endtask

    task automatic send_frame(input logic [79:0] msg, input logic [7:0] crc_x,
                              input logic [7:0] eop, input bit pre11, input bit ack_end);
        exp_t       e;
        logic [7:0] fb[13];
        fb[0] = DEF_SOP_BYTE;
        for (int i = 0; i < 10; i++) fb[1+i] = msg[79-8*i -: 8];
        fb[11] = ref_crc(msg) ^ crc_x;
        fb[12] = eop;
        e.data = model_data;
        e.lat  = 52;
        if (crc_x != 8'h00) begin
            e.kind = K_CRC;
            e.lat  = 48;
            model_err++;
            if (ack_end) model_valid = 1'b0;
        end else if (eop != DEF_EOP_BYTE) begin
            e.kind = K_FRM;
            model_err++;
            if (ack_end) model_valid = 1'b0;
        end else if (model_valid && !ack_end) begin
            e.kind = K_OVF;
            model_err++;
        end else begin
            e.kind      = K_GOOD;
            e.data      = msg[75:0];
            model_valid = 1'b1;
            model_data  = msg[75:0];
            model_good++;
        end
        if (pre11) begin
            @(negedge clk);
            rx = 2'b11;
        end
        for (int j = 0; j < 52; j++) begin
            @(negedge clk);
            rx = 2'(fb[j/4] >> (6 - 2*(j%4)));
            if (j == 0) begin
                e.start = cyc + 1;
                sb.push_back(e);
            end
        end
        if (ack_end) begin
            @(negedge clk);
            rx = 2'b00;
            up_if.data_ack_i = 1'b1;
            @(negedge clk);
            up_if.data_ack_i = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 80'(sb.size()), 80'(0));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_good_cnt"}, 80'(up_if.good_cnt_o), 80'(model_good));
        check({tag, "_err_cnt"}, 80'(up_if.err_cnt_o), 80'(model_err));
    endtask

    function automatic logic [79:0] rnd_msg();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        logic [79:0] p0, pa, pb, pc, pd, pe;
        logic [7:0]  bad_eops[3];
        int          r, g;
        bit          ack_end;
        bad_eops[0] = 8'hDD;
        bad_eops[1] = 8'h5C;
        bad_eops[2] = 8'hDE;
        p0 = 80'h0_1234_5678_9ABC_DEF0_123;
        pa = rnd_msg();
        pb = rnd_msg();
        pc = rnd_msg();
        pd = rnd_msg();
        pe = rnd_msg();
        up_if.data_ack_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 80'(up_if.data_valid_o), 80'(0));
        check("rst_data", {4'h0, up_if.data_rec_o}, 80'(0));
        check("rst_pulses", 80'({up_if.irq_elink_rec, up_if.crc_err_o,
                                 up_if.frame_err_o, up_if.overflow_o}), 80'(0));
        check_counts("rst");
        rst = 1'b1;
        idle(4);

        // Good frame with the reference payload
        send_frame(p0, 8'h00, DEF_EOP_BYTE, 1'b0, 1'b0);
        drain();
        check_counts("good");
        do_ack();

        // Corrupted CRC
        send_frame(p0, 8'h01, DEF_EOP_BYTE, 1'b0, 1'b0);
        drain();
        check("crc_no_valid", 80'(up_if.data_valid_o), 80'(0));
        check_counts("crc");

        // Odd dibit phase and bad end delimiter
        idle(2);
        send_frame(pa, 8'h00, 8'hDD, 1'b1, 1'b0);
        drain();
        check("eop_no_valid", 80'(up_if.data_valid_o), 80'(0));
        check_counts("eop");

        // Back-to-back good frames without ack, then a third after ack
        idle(3);
        send_frame(pa, 8'h00, DEF_EOP_BYTE, 1'b0, 1'b0);
        send_frame(pb, 8'h00, DEF_EOP_BYTE, 1'b0, 1'b0);
        drain();
        check("ovf_keeps_first", {4'h0, up_if.data_rec_o}, {4'h0, pa[75:0]});
        check_counts("ovf");
        do_ack();
        idle(3);
        send_frame(pc, 8'h00, DEF_EOP_BYTE, 1'b0, 1'b0);
        drain();
        check("third_loaded", {4'h0, up_if.data_rec_o}, {4'h0, pc[75:0]});
        do_ack();

        // Ack while empty is ignored
        do_ack();
        check_counts("idle_ack");

        // Ack in the very cycle the second frame's EOP is judged
        send_frame(pd, 8'h00, DEF_EOP_BYTE, 1'b0, 1'b0);
        idle(2);
        send_frame(pe, 8'h00, DEF_EOP_BYTE, 1'b0, 1'b1);
        drain();
        check("coincident_ack_data", {4'h0, up_if.data_rec_o}, {4'h0, pe[75:0]});
        check_counts("coincident");
        do_ack();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            ack_end = ($urandom_range(0, 3) == 0);
            if (r < 2)
                send_frame(rnd_msg(), 8'($urandom_range(1, 255)), DEF_EOP_BYTE,
                           1'($urandom_range(0, 1)), ack_end);
            else if (r == 2)
                send_frame(rnd_msg(), 8'h00, bad_eops[$urandom_range(0, 2)],
                           1'($urandom_range(0, 1)), ack_end);
            else
                send_frame(rnd_msg(), 8'h00, DEF_EOP_BYTE, 1'($urandom_range(0, 1)), ack_end);
            g = $urandom_range(0, 2);
            if (g == 1) idle($urandom_range(1, 5));
            else if (g == 2) do_ack();
        end
        drain();
        check_counts("random");
        check("random_valid", 80'(up_if.data_valid_o), 80'(model_valid));

        // Reset in the middle of payload byte 5, then a clean frame
        begin
            logic [7:0] fb[13];
            fb[0] = DEF_SOP_BYTE;
            for (int i = 0; i < 10; i++) fb[1+i] = pb[79-8*i -: 8];
            for (int j = 0; j < 26; j++) begin
                @(negedge clk);
                rx = 2'(fb[j/4] >> (6 - 2*(j%4)));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        rx  = 2'b00;
        model_valid = 1'b0;
        model_data  = '0;
        model_good  = 0;
        model_err   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(60);
        check("abort_valid", 80'(up_if.data_valid_o), 80'(0));
        check_counts("abort");
        send_frame(pc, 8'h00, DEF_EOP_BYTE, 1'b0, 1'b0);
        drain();
        check_counts("after_abort");
        check("after_abort_data", {4'h0, up_if.data_rec_o}, {4'h0, pc[75:0]});

        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
